sync_ram_ctrl: RTL and testbench
================================

# sync_ram_ctrl

Parametrised single-port synchronous data memory with a valid/ready request interface, registered read response, self-clearing sweep after reset or on demand, and output-enable gating. Next-generation replacement for the fixed 256×32 calculator memory. Sits between the CalcuTEC datapath/control unit and on-chip RAM.

## Interface
- `DATA_W`, 32: word width in bits; ≥ 8.
- `ADDR_W`, 8: address width; depth `DEPTH = 2**ADDR_W` words.
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `clr` in 1: one-cycle pulse that restarts the clearing sweep.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: word address.
- `req_wdata` in `DATA_W`: write data.
- `req_be` in `DATA_W/8`: byte write enables; present only with `MEM_BYTE_WE_EN`.
- `oe` in 1: output enable for `rsp_data`.
- `rsp_valid` out 1: one-cycle pulse, read data available.
- `rsp_data` out `DATA_W`: read data when `oe`=1, otherwise all zeros (combinational gate on the held register).
- `busy` out 1: high while clearing.

## Operation
- FSM states: `CLEAR` and `RUN`. Sweep counter `clr_addr` is `ADDR_W` bits wide.
- `CLEAR`:
  - Each cycle writes 0 to `mem[clr_addr]`, then increments `clr_addr`.
  - After the edge that writes `DEPTH-1`, state moves to `RUN`.
  - `req_ready`=0 and `busy`=1 throughout.
- `RUN`:
  - `req_ready = !clr`, combinational.
  - Accepted write: `mem[req_addr] <= req_wdata`. No response is generated.
  - Accepted read: the data register loads `mem[req_addr]`, and `rsp_valid`=1 for the next cycle only.
- `clr` in `RUN`: state moves to `CLEAR` and `clr_addr` returns to 0. No request is accepted in that cycle. `clr` during `CLEAR` restarts the sweep at 0.
- The data register holds the last read value until the next accepted read. Writes, including a write to the same address, do not update it.
- Reset (`rst_n`=0 at an edge), from any state and mid-sweep included:
  - state = `CLEAR`, `clr_addr` = 0.
  - `rsp_valid` = 0, data register = 0.
  - Array contents are not reset directly; the sweep clears them.
- Reset value of every output while `rst_n`=0:
  - `req_ready` = 0, `busy` = 1, `rsp_valid` = 0.
  - `rsp_data` = 0 regardless of `oe`.

## Timing
- Clearing takes exactly `DEPTH` rising edges with `rst_n`=1 and `clr`=0. `req_ready` rises after edge number `DEPTH` (256 cycles by default).
- Read latency is 1 cycle: request accepted at edge N, then `rsp_valid`=1 and data valid after edge N, for one cycle.
- Throughput: one request per cycle, reads and writes in any mix, back-to-back.
- Read-after-write to the same address in the next cycle returns the new data.
- A read accepted at edge N+1 after a write at edge N is the only ordering that can occur; same-cycle read and write is impossible on a single port.
- `oe` takes effect combinationally; it never alters the register or `rsp_valid`.

## Configuration
- `MEM_BYTE_WE_EN` defined:
  - Adds the `req_be` port; `DATA_W` must be a multiple of 8.
  - A write updates only the bytes with `req_be[i]`=1.
  - A write with `req_be`=0 is accepted but changes nothing.
  - The clearing sweep always writes full words.
- `MEM_BYTE_WE_EN` undefined: no `req_be` port, and every write updates the full word.

## Test plan
- **Post-reset clear:** hold `rst_n`=0 for 2 cycles, then release.
  - `req_ready`=0 for 256 cycles, then rises with `busy`=0.
  - Reading addresses 0..7 returns 0, with `rsp_data`=0 before the first read.
- **Write and read-back:** write addresses 0..7 with 1, 10, 100, …, 10000000, back-to-back.
  - Reading 0..7 back-to-back returns the same values, each one cycle after its request.
  - `rsp_valid` stays high for 8 consecutive cycles.
- **Overwrite and RAW:** write 102 to address 5, then read 5 in the next cycle.
  - Returns 102.
  - A subsequent idle 10 cycles keep `rsp_data`=102 with `rsp_valid`=0.
- **`oe` gating:** after a read of 102, drive `oe`=0.
  - `rsp_data`=0.
  - On return to `oe`=1, `rsp_data`=102 with no new request.
- **`clr` and reset mid-sweep:**
  - Pulse `clr` in `RUN` with `req_valid`=1: no request is accepted in that cycle.
  - Assert `rst_n`=0 after 100 sweep cycles: the sweep restarts, and `req_ready` rises exactly 256 cycles after release.
  - All addresses read 0 afterwards.
- **Byte enables (`MEM_BYTE_WE_EN`):**
  - Write 0xFFFFFFFF, then write 0x12345678 with `req_be`=4'b0101: reading back gives 0xFF34FF78.
  - A write with `req_be`=0 leaves the word unchanged.

Source files
------------

// File: rtl/sync_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_ctrl_if
//  Description : Request/response bundle between the CalcuTEC datapath
//                (master) and the sync_ram_ctrl data memory (slave).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W     word width in bits
//    ADDR_W     word address width
//  Signals
//    clr        one-cycle pulse restarting the clearing sweep
//    req_valid  request present
//    req_ready  request accepted when req_valid && req_ready at clk rise
//    req_we     1 = write, 0 = read
//    req_addr   word address
//    req_wdata  write data
//    req_be     byte write enables (only with MEM_BYTE_WE_EN)
//    oe         output enable for rsp_data
//    rsp_valid  one-cycle pulse, read data available
//    rsp_data   read data (zero while oe = 0)
//    busy       high while the memory is being cleared
//  Build option
//    MEM_BYTE_WE_EN  adds req_be and per-byte write masking
// ============================================================================
interface sync_ram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);

  logic              clr;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef MEM_BYTE_WE_EN
  logic [DATA_W/8-1:0] req_be;
`endif
  logic              oe;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  // Datapath side: issues requests, consumes responses.
  modport master (
`ifdef MEM_BYTE_WE_EN
    output req_be,
`endif
    output clr,
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output oe,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  busy
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
`ifdef MEM_BYTE_WE_EN
    input  req_be,
`endif
    input  clr,
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  oe,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output busy
  );

endinterface : sync_ram_ctrl_if
`default_nettype wire

// File: rtl/sync_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ram_ctrl
//  Description : Parametrised single-port synchronous data memory with a
//                valid/ready request port, a registered one-cycle read
//                response, a self-clearing sweep after reset or on clr, and
//                combinational output-enable gating of the read data.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W   word width in bits (>= 8; multiple of 8 with MEM_BYTE_WE_EN)
//    ADDR_W   address width, DEPTH = 2**ADDR_W words
//  Ports
//    clk      the only clock, rising edge
//    rst_n    synchronous active-low reset
//    bus      sync_ram_ctrl_if.slave: clr, req_*, oe, rsp_*, busy
//  Build option
//    MEM_BYTE_WE_EN  when defined, writes honour bus.req_be per byte; the
//                    clearing sweep always writes full words. Undefined
//                    (default): every write updates the full word.
// ============================================================================
module sync_ram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  sync_ram_ctrl_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_BYTE_WE_EN
  localparam int BE_W  = DATA_W / 8;
`endif

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Sweep pointer; wraps naturally to 0 after the last word.
  logic [ADDR_W-1:0] r_clr_addr;

  // Storage and read response register.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rsp_valid;

  // FSM decode outputs.
  logic              w_req_ready;
  logic              w_busy;
  logic              w_sweep_en;
  logic              w_sweep_last;

  // Request decode.
  logic              w_accept;
  logic              w_wr_en;
  logic              w_rd_en;

  // Single write port shared by the sweep and accepted writes.
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
`ifdef MEM_BYTE_WE_EN
  logic [BE_W-1:0]   w_mem_be;
`endif

  assign w_sweep_last = &r_clr_addr;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_busy      = 1'b1;
    w_sweep_en  = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        w_busy = 1'b1;
        // A clr pulse mid-sweep only rewinds the pointer; the word at the
        // current pointer is revisited on the restarted pass anyway.
        if (!bus.clr) begin
          w_sweep_en = 1'b1;
          if (w_sweep_last) begin
            w_state_nxt = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        w_busy      = 1'b0;
        // clr takes precedence over any request presented in the same cycle.
        w_req_ready = !bus.clr;
        if (bus.clr) begin
          w_state_nxt = ST_CLEAR;
        end
      end

      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sweep pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_addr <= '0;
    end else if (bus.clr) begin
      r_clr_addr <= '0;
    end else if (w_sweep_en) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_accept = rst_n & bus.req_valid & w_req_ready;
  assign w_wr_en  = w_accept &  bus.req_we;
  assign w_rd_en  = w_accept & ~bus.req_we;

  // --------------------------------------------------------------------------
  // Write port mux: the sweep and requests are mutually exclusive by state.
  // --------------------------------------------------------------------------
  assign w_mem_we    = rst_n & (w_sweep_en | w_wr_en);
  assign w_mem_addr  = w_sweep_en ? r_clr_addr : bus.req_addr;
  assign w_mem_wdata = w_sweep_en ? '0         : bus.req_wdata;
`ifdef MEM_BYTE_WE_EN
  assign w_mem_be    = w_sweep_en ? {BE_W{1'b1}} : bus.req_be;
`endif

  // --------------------------------------------------------------------------
  // Storage array (no reset: contents are cleared by the sweep)
  // --------------------------------------------------------------------------
`ifdef MEM_BYTE_WE_EN
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_mem_be[b]) begin
          r_mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read response register. Holds the last read word until the next
  // accepted read; writes never touch it, even to the same address.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data   <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data <= r_mem[bus.req_addr];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Gating with rst_n makes every output show its reset value as
  // soon as reset is asserted, before the first reset edge arrives.
  // --------------------------------------------------------------------------
  assign bus.req_ready = rst_n & w_req_ready;
  assign bus.busy      = ~rst_n | w_busy;
  assign bus.rsp_valid = rst_n & r_rsp_valid;
  assign bus.rsp_data  = (rst_n & bus.oe) ? r_rd_data : '0;

endmodule : sync_ram_ctrl
`default_nettype wire

// File: tb/tb_sync_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_ram_ctrl
//  Description : Directed self-checking bench for sync_ram_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_ram_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sync_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sync_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef MEM_BYTE_WE_EN
    bus.req_be    = '1;
`endif
  endtask

  // Count edges after reset release until req_ready rises (bounded).
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (cnt < DEPTH + 50) begin
      cycle();
      cnt++;
      if (bus.req_ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.oe  = 1'b1;
    bus.clr = 1'b0;
    idle_req();
    cycle();
    cycle();
    n_tests++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
    end
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b want 1", bus.busy);
    end
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
    end
    n_tests++;
    if (bus.rsp_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data);
    end
  endtask

  task automatic test_clear_sweep();
    int cnt;
    rst_n = 1'b1;
    wait_ready(cnt);
    n_tests++;
    if (cnt !== DEPTH) begin
      n_fail++; $display("FAIL sweep_len: got %0d edges want %0d", cnt, DEPTH);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL sweep_busy_done: got %b want 0", bus.busy);
    end
    n_tests++;
    if (bus.rsp_data !== 32'd0) begin
      n_fail++; $display("FAIL pre_read_rsp_data: got %h want 0", bus.rsp_data);
    end
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 8'(i);
      cycle();
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd0) begin
        n_fail++;
        $display("FAIL cleared_read[%0d]: got v=%b d=%h want v=1 d=0", i, bus.rsp_valid, bus.rsp_data);
      end
    end
    idle_req();
    cycle();
  endtask

  task automatic test_write_read();
    logic [31:0] exp_val [8];
    int          run;
    exp_val = '{32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000, 32'd1000000, 32'd10000000};
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 8'(i);
      bus.req_wdata = exp_val[i];
      cycle();
      n_tests++;
      if (bus.rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL write_no_rsp[%0d]: got %b want 0", i, bus.rsp_valid);
      end
    end
    run = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 8'(i);
      cycle();
      if (bus.rsp_valid === 1'b1) run++;
      n_tests++;
      if (bus.rsp_data !== exp_val[i]) begin
        n_fail++; $display("FAIL readback[%0d]: got %0d want %0d", i, bus.rsp_data, exp_val[i]);
      end
    end
    idle_req();
    n_tests++;
    if (run !== 8) begin
      n_fail++; $display("FAIL rsp_valid_run: got %0d want 8", run);
    end
    cycle();
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_valid_drop: got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_raw();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'd5;
    bus.req_wdata = 32'd102;
    cycle();
    bus.req_we    = 1'b0;
    cycle();
    idle_req();
    n_tests++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd102) begin
      n_fail++; $display("FAIL raw: got v=%b d=%0d want v=1 d=102", bus.rsp_valid, bus.rsp_data);
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_tests++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd102) begin
        n_fail++; $display("FAIL hold[%0d]: got v=%b d=%0d want v=0 d=102", i, bus.rsp_valid, bus.rsp_data);
      end
    end
    // A write to the same address must not disturb the held register.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'd5;
    bus.req_wdata = 32'd77;
    cycle();
    idle_req();
    n_tests++;
    if (bus.rsp_data !== 32'd102) begin
      n_fail++; $display("FAIL hold_after_write: got %0d want 102", bus.rsp_data);
    end
    // Restore address 5 and reload the register with 102.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'd102;
    bus.req_addr  = 8'd5;
    cycle();
    bus.req_we    = 1'b0;
    cycle();
    idle_req();
  endtask

  task automatic test_oe();
    bus.oe = 1'b0;
    #1;
    n_tests++;
    if (bus.rsp_data !== 32'd0) begin
      n_fail++; $display("FAIL oe_low: got %h want 0", bus.rsp_data);
    end
    cycle();
    n_tests++;
    if (bus.rsp_data !== 32'd0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL oe_low_hold: got v=%b d=%h want v=0 d=0", bus.rsp_valid, bus.rsp_data);
    end
    bus.oe = 1'b1;
    #1;
    n_tests++;
    if (bus.rsp_data !== 32'd102) begin
      n_fail++; $display("FAIL oe_restore: got %0d want 102", bus.rsp_data);
    end
  endtask

  task automatic test_clr_and_reset_midsweep();
    int cnt;
    // clr with a read pending: the read must not be taken.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'd0;
    bus.clr       = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL clr_ready: got %b want 0", bus.req_ready);
    end
    cycle();
    bus.clr = 1'b0;
    idle_req();
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL clr_no_accept: got v=%b busy=%b want v=0 busy=1", bus.rsp_valid, bus.busy);
    end
    repeat (100) cycle();
    n_tests++;
    if (bus.req_ready !== 1'b0 || bus.rsp_data !== 32'd102) begin
      n_fail++; $display("FAIL midsweep: got rdy=%b d=%0d want rdy=0 d=102", bus.req_ready, bus.rsp_data);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.rsp_data !== 32'd0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_gate: got d=%h busy=%b want d=0 busy=1", bus.rsp_data, bus.busy);
    end
    cycle();
    rst_n = 1'b1;
    wait_ready(cnt);
    n_tests++;
    if (cnt !== DEPTH) begin
      n_fail++; $display("FAIL resweep_len: got %0d edges want %0d", cnt, DEPTH);
    end
    n_tests++;
    if (bus.rsp_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_clears_reg: got %h want 0", bus.rsp_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 8'(i);
      cycle();
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd0) begin
        n_fail++; $display("FAIL all_zero[%0d]: got v=%b d=%h want v=1 d=0", i, bus.rsp_valid, bus.rsp_data);
      end
    end
    idle_req();
    cycle();
  endtask

`ifdef MEM_BYTE_WE_EN
  task automatic test_byte_we();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'd9;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_be    = 4'b1111;
    cycle();
    bus.req_wdata = 32'h1234_5678;
    bus.req_be    = 4'b0101;
    cycle();
    bus.req_we    = 1'b0;
    cycle();
    n_tests++;
    if (bus.rsp_data !== 32'hFF34_FF78) begin
      n_fail++; $display("FAIL byte_we: got %h want ff34ff78", bus.rsp_data);
    end
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h0000_0000;
    bus.req_be    = 4'b0000;
    cycle();
    bus.req_we    = 1'b0;
    cycle();
    idle_req();
    n_tests++;
    if (bus.rsp_data !== 32'hFF34_FF78) begin
      n_fail++; $display("FAIL byte_we_none: got %h want ff34ff78", bus.rsp_data);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_raw();
    test_oe();
    test_clr_and_reset_midsweep();
`ifdef MEM_BYTE_WE_EN
    test_byte_we();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sync_ram_ctrl
`default_nettype wire
